// File: rtl/elevator_pkg.sv
// Shared floor/button layout, direction and controller-state types for the elevator cars.
// Also imported by the hall-call allocator.
package elevator_pkg;
   localparam int NUM_FLOORS = 7;
   localparam int BUTTON_W   = 14;
   localparam int UP_BASE    = 0;
   localparam int DOWN_BASE  = 7;
   localparam int FLOOR_W    = 3;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_t;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR_OPEN
   } state_t;

   // One-hot floor select; avoids variable indexing with a 3-bit floor into a 7-bit vector.
   function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
      floor_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++)
         if (FLOOR_W'(i) == f) floor_mask[i] = 1'b1;
   endfunction
endpackage

// File: rtl/car_request_scan.sv
// Combinational request scan relative to one floor: any request above, below, or at it.
module car_request_scan
   import elevator_pkg::*;
(
   input  logic [BUTTON_W-1:0]   i_floorButton,
   input  logic [NUM_FLOORS-1:0] i_carCall,
   input  logic [FLOOR_W-1:0]    i_floor,
   output logic                  o_anyAbove,
   output logic                  o_anyBelow,
   output logic                  o_reqHere
);
   logic [NUM_FLOORS-1:0] w_req;

   assign w_req = i_carCall | i_floorButton[UP_BASE +: NUM_FLOORS]
                            | i_floorButton[DOWN_BASE +: NUM_FLOORS];

   always_comb begin
      o_anyAbove = 1'b0;
      o_anyBelow = 1'b0;
      o_reqHere  = 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (FLOOR_W'(f) > i_floor)  o_anyAbove = o_anyAbove | w_req[f];
         if (FLOOR_W'(f) < i_floor)  o_anyBelow = o_anyBelow | w_req[f];
         if (FLOOR_W'(f) == i_floor) o_reqHere  = w_req[f];
      end
   end
endmodule

// File: rtl/elevator_car_controller.sv
// Per-car motion/door controller: travels floor by floor, times the door, drops served calls.
// DOOR_HOLD_EN adds a doorHold input that keeps the door open while asserted.
module elevator_car_controller
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 100,
   parameter int DOOR_CYCLES   = 50,
   parameter int INIT_FLOOR    = 0
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BUTTON_W-1:0]   floorButton,
   input  logic [NUM_FLOORS-1:0] carButton,
`ifdef DOOR_HOLD_EN
   input  logic                  doorHold,
`endif
   output logic [BUTTON_W-1:0]   nextFloorButton,
   output logic [1:0]            direction,
   output logic [FLOOR_W-1:0]    currentFloor,
   output logic                  doorOpen
);
   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW      = $clog2(MAX_CYC);
   localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0]      DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

   state_t                r_state;
   dir_t                  r_dir;
   logic [FLOOR_W-1:0]    r_floor;
   logic                  r_door;
   logic [BUTTON_W-1:0]   r_nfb;
   logic [NUM_FLOORS-1:0] r_carCall;
   logic [TW-1:0]         r_timer;

   logic                  w_aboveCur, w_belowCur, w_hereCur;
   logic                  w_aboveNxt, w_belowNxt, w_hereNxt;
   logic [FLOOR_W-1:0]    w_nextFloor;
   logic [NUM_FLOORS-1:0] w_curMask, w_nxtMask, w_ccClr;
   logic                  w_carNxt, w_upNxt, w_downNxt, w_aheadNxt, w_stop, w_hold;
   logic [BUTTON_W-1:0]   w_servedMask;
   dir_t                  w_doorDir;

`ifdef DOOR_HOLD_EN
   assign w_hold = doorHold;
`else
   assign w_hold = 1'b0;
`endif

   // Floor the car would reach on this step; saturates so the floor can never wrap.
   assign w_nextFloor = (r_dir == DIR_DOWN) ? ((r_floor == '0) ? r_floor : r_floor - 3'd1)
                                            : ((r_floor == TOP_FLOOR) ? r_floor : r_floor + 3'd1);
   assign w_curMask = floor_mask(r_floor);
   assign w_nxtMask = floor_mask(w_nextFloor);

   car_request_scan u_scan_cur (
      .i_floorButton (floorButton), .i_carCall (r_carCall), .i_floor (r_floor),
      .o_anyAbove (w_aboveCur), .o_anyBelow (w_belowCur), .o_reqHere (w_hereCur)
   );

   car_request_scan u_scan_nxt (
      .i_floorButton (floorButton), .i_carCall (r_carCall), .i_floor (w_nextFloor),
      .o_anyAbove (w_aboveNxt), .o_anyBelow (w_belowNxt), .o_reqHere (w_hereNxt)
   );

   assign w_carNxt   = |(r_carCall & w_nxtMask);
   assign w_upNxt    = |(floorButton[UP_BASE +: NUM_FLOORS] & w_nxtMask);
   assign w_downNxt  = |(floorButton[DOWN_BASE +: NUM_FLOORS] & w_nxtMask);
   assign w_aheadNxt = (r_dir == DIR_UP) ? w_aboveNxt : w_belowNxt;
   assign w_stop     = w_carNxt | ((r_dir == DIR_UP) ? w_upNxt : w_downNxt) | (!w_aheadNxt & w_hereNxt);

   // Car calls drop on door entry, and presses for this floor are swallowed while open.
   always_comb begin
      w_ccClr = '0;
      if (r_state == DOOR_OPEN || (r_state == IDLE && w_hereCur)) w_ccClr = w_curMask;
      else if (r_state == MOVE && r_timer == '0 && w_stop)      w_ccClr = w_nxtMask;
   end

   always_comb begin
      w_servedMask = '0;
      if (r_state == DOOR_OPEN) begin
         if (r_dir != DIR_DOWN) w_servedMask[UP_BASE +: NUM_FLOORS]   = w_curMask;
         if (r_dir != DIR_UP)   w_servedMask[DOWN_BASE +: NUM_FLOORS] = w_curMask;
      end
   end

   // Departure direction after the door closes: keep going if possible, else reverse.
   always_comb begin
      w_doorDir = DIR_IDLE;
      if (r_dir == DIR_DOWN) begin
         if (w_belowCur)      w_doorDir = DIR_DOWN;
         else if (w_aboveCur) w_doorDir = DIR_UP;
      end else begin
         if (w_aboveCur)      w_doorDir = DIR_UP;
         else if (w_belowCur) w_doorDir = DIR_DOWN;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_dir     <= DIR_IDLE;
         r_floor   <= FLOOR_W'(INIT_FLOOR);
         r_door    <= 1'b0;
         r_nfb     <= '0;
         r_carCall <= '0;
         r_timer   <= '0;
      end else begin
         r_nfb     <= floorButton & ~w_servedMask;
         r_carCall <= (r_carCall | carButton) & ~w_ccClr;
         case (r_state)
            IDLE: begin
               if (w_hereCur) begin
                  r_state <= DOOR_OPEN;
                  r_door  <= 1'b1;
                  r_dir   <= DIR_IDLE;
                  r_timer <= DOOR_LOAD;
               end else if (w_aboveCur || w_belowCur) begin
                  r_state <= MOVE;
                  r_dir   <= w_aboveCur ? DIR_UP : DIR_DOWN;
                  r_timer <= TRAVEL_LOAD;
               end
            end
            MOVE: begin
               if (r_timer != '0) begin
                  r_timer <= r_timer - TW'(1);
               end else begin
                  r_floor <= w_nextFloor;
                  if (w_stop) begin
                     r_state <= DOOR_OPEN;
                     r_door  <= 1'b1;
                     r_timer <= DOOR_LOAD;
                     if (!w_aheadNxt && (w_upNxt || w_downNxt)) r_dir <= w_downNxt ? DIR_DOWN : DIR_UP;
                  end else begin
                     r_timer <= TRAVEL_LOAD;
                     if (w_nextFloor == TOP_FLOOR) r_dir <= DIR_DOWN;
                     else if (w_nextFloor == '0)   r_dir <= DIR_UP;
                  end
               end
            end
            DOOR_OPEN: begin
               if (w_hold) begin
                  r_timer <= DOOR_LOAD;
               end else if (r_timer != '0) begin
                  r_timer <= r_timer - TW'(1);
               end else begin
                  r_door <= 1'b0;
                  r_dir  <= w_doorDir;
                  if (w_doorDir != DIR_IDLE) begin
                     r_state <= MOVE;
                     r_timer <= TRAVEL_LOAD;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign nextFloorButton = r_nfb;
   assign direction       = r_dir;
   assign currentFloor    = r_floor;
   assign doorOpen        = r_door;
endmodule

// File: doc/elevator_car_controller.md
Name: elevator_car_controller

Overview:
Per-car motion and door controller for the 2-car, 7-floor elevator; instantiated twice, downstream of the hall-call allocator.
- Consumes the 14-bit hall-call vector assigned to this car, plus its own cabin buttons.
- Moves the car floor by floor, opens and times the door, and drops served calls.
- Returns the remaining calls and the car's travel direction to the allocator for re-allocation on the next cycle.

Parameters:
TRAVEL_CYCLES, 100, clk cycles to travel one floor (>=2)
DOOR_CYCLES, 50, clk cycles the door stays open (>=2)
INIT_FLOOR, 0, floor index the car occupies after reset (0..6)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
floorButton  input  14  hall calls owned by this car; bit f = up call at floor f, bit 7+f = down call at floor f (f = 0..6)
carButton  input  7  cabin buttons, level, bit f = floor f
nextFloorButton  output  14  registered: floorButton with served bits cleared
direction  output  2  registered: 00 idle, 01 up, 10 down; 11 never driven
currentFloor  output  3  registered floor index 0..6
doorOpen  output  1  registered, high throughout DOOR_OPEN

Behaviour:
Reset values:
- state IDLE, currentFloor = INIT_FLOOR, direction = 00, doorOpen = 0.
- nextFloorButton = 0, latched car calls = 0, timer = 0.

Car calls:
- carCall[f] is set by carButton[f].
- It is cleared when DOOR_OPEN is entered at floor f.
- A press for currentFloor while in DOOR_OPEN is absorbed and not latched.

Request terms:
- "Request at f" = carCall[f] | floorButton[f] | floorButton[7+f].
- "Ahead" = any request strictly above currentFloor (direction up) or strictly below (direction down).

State IDLE:
- Request at currentFloor -> DOOR_OPEN, direction 00.
- Else any request above -> direction 01, MOVE.
- Else any request below -> direction 10, MOVE.
- Above wins over below on a tie.

State MOVE:
- Timer loads TRAVEL_CYCLES-1 and counts to 0.
- At 0, currentFloor steps +1/-1; the stop decision uses the new floor in the same cycle.
- Stop if any of: carCall at floor; hall call at floor in the current direction; nothing ahead and any hall call at floor.
- In the last case, direction flips to the direction of that call (down preferred if both).
- Stop -> DOOR_OPEN; otherwise reload the timer and stay in MOVE.
- Floor never wraps. Direction is forced so that floor 6 is never left going up and floor 0 is never left going down.

State DOOR_OPEN:
- doorOpen = 1; timer loads DOOR_CYCLES-1 and counts to 0.
- At 0: if requests ahead -> MOVE, same direction.
- Else if requests behind -> reverse direction, MOVE.
- Else -> IDLE, direction 00.

Served mask (held for the whole DOOR_OPEN state, so calls echoed back by the allocator stay cleared):
- direction 01 clears bit f.
- direction 10 clears bit 7+f.
- direction 00 clears both.

Output latency and events:
- nextFloorButton <= floorButton & ~servedMask every cycle (1-cycle latency).
- Outside DOOR_OPEN the mask is 0.
- A hall call and a car call arriving together are both honoured.
- floorButton bits withdrawn by the allocator mid-MOVE simply stop influencing decisions; no glitch on currentFloor.
- Reset asserted mid-travel returns the car to INIT_FLOOR instantly (model only).

Optional Feature:
DOOR_HOLD_EN
- Defined: adds input doorHold (1 bit). While doorHold = 1 in DOOR_OPEN, the door timer reloads DOOR_CYCLES-1, so the door closes DOOR_CYCLES cycles after release. doorHold has no effect in other states.
- Undefined: the port is absent and the door time is fixed at DOOR_CYCLES.

Decomposition:
Shared package elevator_pkg holds:
- NUM_FLOORS = 7 and the BUTTON_W = 14 bit-layout constants (UP_BASE = 0, DOWN_BASE = 7).
- Direction typedef (DIR_IDLE / DIR_UP / DIR_DOWN).
- Controller state typedef (IDLE / MOVE / DOOR_OPEN).

The allocator imports the same package. One sub-module is natural: car_request_scan, a combinational block taking the request vectors and currentFloor and producing anyAbove, anyBelow and reqHere.

Test Plan:
- Reset with INIT_FLOOR = 0, no inputs -> IDLE, direction 00, currentFloor 0, doorOpen 0, nextFloorButton 0.
- floorButton = 14'h0008 (up call floor 3) from floor 0 -> direction 01 next cycle; currentFloor 3 after 3*TRAVEL_CYCLES; doorOpen 1; nextFloorButton bit 3 = 0 while open; IDLE after DOOR_CYCLES.
- Car at floor 1 moving up, carButton[5] latched, down call at floor 3 (bit 10) -> passes floor 3 without stopping, stops at 5, reverses, stops at 3 with direction 10, bit 10 cleared.
- Car IDLE at floor 6, down call at floor 6 plus up call at floor 0 -> door opens at 6 first, then direction 10, arrives at floor 0, direction flips to 01, bit 0 cleared.
- Assert reset while in MOVE between floors 2 and 3 -> all outputs return to reset values in the same cycle, asynchronously.
- DOOR_HOLD_EN defined: hold doorHold for 200 cycles during DOOR_OPEN -> door stays open 200 + DOOR_CYCLES cycles total.
